// File: rtl/alu_issue_queue_pkg.sv
// Shared defaults and sizing helpers for the ALU issue queue slice.
package alu_issue_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT     = 8;
    localparam int IQ_PREG_W_DEFAULT    = 6;
    localparam int IQ_PAYLOAD_W_DEFAULT = 64;
    localparam int IQ_WB_PORTS_DEFAULT  = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup and issue signals of the ALU issue queue; master drives dispatch/wakeup.
interface alu_issue_queue_if
    import alu_issue_queue_pkg::*;
#(
    parameter int PREG_W    = IQ_PREG_W_DEFAULT,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W_DEFAULT,
    parameter int WB_PORTS  = IQ_WB_PORTS_DEFAULT
) ();

    logic                             flush_i;
    logic                             dispatch_valid_i;
    logic                             dispatch_ready_o;
    logic [PREG_W-1:0]                dispatch_psrc0_i;
    logic [PREG_W-1:0]                dispatch_psrc1_i;
    logic                             dispatch_rdy0_i;
    logic                             dispatch_rdy1_i;
    logic [PREG_W-1:0]                dispatch_pdest_i;
    logic [PAYLOAD_W-1:0]             dispatch_payload_i;
    logic [WB_PORTS-1:0]              wb_valid_i;
    logic [WB_PORTS-1:0][PREG_W-1:0]  wb_preg_i;
    logic                             issue_valid_o;
    logic                             issue_ready_i;
    logic [PREG_W-1:0]                issue_psrc0_o;
    logic [PREG_W-1:0]                issue_psrc1_o;
    logic [PREG_W-1:0]                issue_pdest_o;
    logic [PAYLOAD_W-1:0]             issue_payload_o;

    modport master (
        output flush_i, dispatch_valid_i, dispatch_psrc0_i, dispatch_psrc1_i,
               dispatch_rdy0_i, dispatch_rdy1_i, dispatch_pdest_i, dispatch_payload_i,
               wb_valid_i, wb_preg_i, issue_ready_i,
        input  dispatch_ready_o, issue_valid_o, issue_psrc0_o, issue_psrc1_o,
               issue_pdest_o, issue_payload_o
    );

    modport slave (
        input  flush_i, dispatch_valid_i, dispatch_psrc0_i, dispatch_psrc1_i,
               dispatch_rdy0_i, dispatch_rdy1_i, dispatch_pdest_i, dispatch_payload_i,
               wb_valid_i, wb_preg_i, issue_ready_i,
        output dispatch_ready_o, issue_valid_o, issue_psrc0_o, issue_psrc1_o,
               issue_pdest_o, issue_payload_o
    );

endinterface

// File: rtl/alu_iq_select.sv
// Oldest-first picker: lowest-index set bit of the eligible vector as a one-hot grant.
module alu_iq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant,
    output logic             found
);

    always_comb begin
        logic lower_seen;
        lower_seen = 1'b0;
        grant      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i]   = eligible[i] & ~lower_seen;
            lower_seen = lower_seen | eligible[i];
        end
    end

    assign found = |eligible;

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing out-of-order issue queue for the ALU pipe with wakeup and registered issue port.
// Optional same-cycle bypass of an empty queue: define ALU_IQ_BYPASS_EN.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH_DEFAULT,
    parameter int PREG_W    = IQ_PREG_W_DEFAULT,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W_DEFAULT,
    parameter int WB_PORTS  = IQ_WB_PORTS_DEFAULT
) (
    input logic              clk,
    input logic              a_rst,
    alu_issue_queue_if.slave iq
);

    localparam int CNT_W = count_width(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 rdy0;
        logic                 rdy1;
        logic [PREG_W-1:0]    psrc0;
        logic [PREG_W-1:0]    psrc1;
        logic [PREG_W-1:0]    pdest;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    psrc0;
        logic [PREG_W-1:0]    psrc1;
        logic [PREG_W-1:0]    pdest;
        logic [PAYLOAD_W-1:0] payload;
    } issue_t;

    entry_t           entry_reg   [DEPTH];
    entry_t           entry_woken [DEPTH];
    entry_t           entry_next  [DEPTH];
    logic [CNT_W-1:0] count_reg, count_next;
    issue_t           issue_reg, issue_next;

    logic [DEPTH-1:0] eligible, grant;
    logic             found, issue_free, transfer, dispatch_fire, bypass, write_en;
    logic             disp_hit0, disp_hit1;
    entry_t           disp_entry, sel_entry;
    logic [CNT_W-1:0] wr_pos;

    // Registered ready bits pick up this cycle's broadcasts for the next state only;
    // eligibility below deliberately uses the registered copy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic hit0, hit1;
            always_comb begin
                hit0 = 1'b0;
                hit1 = 1'b0;
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (iq.wb_valid_i[p] && iq.wb_preg_i[p] == entry_reg[gi].psrc0) hit0 = 1'b1;
                    if (iq.wb_valid_i[p] && iq.wb_preg_i[p] == entry_reg[gi].psrc1) hit1 = 1'b1;
                end
            end
            assign entry_woken[gi] = '{valid:   entry_reg[gi].valid,
                                       rdy0:    entry_reg[gi].rdy0 | hit0,
                                       rdy1:    entry_reg[gi].rdy1 | hit1,
                                       psrc0:   entry_reg[gi].psrc0,
                                       psrc1:   entry_reg[gi].psrc1,
                                       pdest:   entry_reg[gi].pdest,
                                       payload: entry_reg[gi].payload};
            assign eligible[gi] = entry_reg[gi].valid & entry_reg[gi].rdy0 & entry_reg[gi].rdy1;
        end
    endgenerate

    always_comb begin
        disp_hit0 = 1'b0;
        disp_hit1 = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (iq.wb_valid_i[p] && iq.wb_preg_i[p] == iq.dispatch_psrc0_i) disp_hit0 = 1'b1;
            if (iq.wb_valid_i[p] && iq.wb_preg_i[p] == iq.dispatch_psrc1_i) disp_hit1 = 1'b1;
        end
    end

    assign disp_entry = '{valid:   1'b1,
                          rdy0:    iq.dispatch_rdy0_i | disp_hit0,
                          rdy1:    iq.dispatch_rdy1_i | disp_hit1,
                          psrc0:   iq.dispatch_psrc0_i,
                          psrc1:   iq.dispatch_psrc1_i,
                          pdest:   iq.dispatch_pdest_i,
                          payload: iq.dispatch_payload_i};

    alu_iq_select #(.DEPTH(DEPTH)) u_select (
        .eligible (eligible),
        .grant    (grant),
        .found    (found)
    );

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_entry = entry_reg[i];
        end
    end

    assign iq.dispatch_ready_o = (count_reg != CNT_W'(DEPTH));
    assign issue_free          = !issue_reg.valid || iq.issue_ready_i;
    assign transfer            = issue_free && found && !iq.flush_i;
    assign dispatch_fire       = iq.dispatch_valid_i && iq.dispatch_ready_o && !iq.flush_i;

`ifdef ALU_IQ_BYPASS_EN
    assign bypass = dispatch_fire && (count_reg == '0) && disp_entry.rdy0 && disp_entry.rdy1 && issue_free;
`else
    assign bypass = 1'b0;
`endif

    assign write_en   = dispatch_fire && !bypass;
    assign wr_pos     = count_reg - CNT_W'(transfer);
    assign count_next = iq.flush_i ? '0 : count_reg + CNT_W'(write_en) - CNT_W'(transfer);

    // Collapse everything at or above the granted slot, then append the new op at the tail.
    always_comb begin
        logic passed;
        passed = 1'b0;
        for (int i = 0; i < DEPTH; i++) entry_next[i] = entry_woken[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            passed = passed | grant[i];
            if (transfer && passed) entry_next[i] = entry_woken[i+1];
        end
        if (transfer) entry_next[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en && wr_pos == CNT_W'(i)) entry_next[i] = disp_entry;
        end
        if (iq.flush_i) begin
            for (int i = 0; i < DEPTH; i++) entry_next[i] = '0;
        end
    end

    always_comb begin
        issue_next = issue_reg;
        if (iq.flush_i) begin
            issue_next = '0;
        end else if (transfer) begin
            issue_next = '{1'b1, sel_entry.psrc0, sel_entry.psrc1, sel_entry.pdest, sel_entry.payload};
        end else if (bypass) begin
            issue_next = '{1'b1, disp_entry.psrc0, disp_entry.psrc1, disp_entry.pdest, disp_entry.payload};
        end else if (iq.issue_ready_i) begin
            issue_next = '0;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            count_reg <= '0;
            issue_reg <= '0;
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            count_reg <= count_next;
            issue_reg <= issue_next;
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
        end
    end

    assign iq.issue_valid_o   = issue_reg.valid;
    assign iq.issue_psrc0_o   = issue_reg.psrc0;
    assign iq.issue_psrc1_o   = issue_reg.psrc1;
    assign iq.issue_pdest_o   = issue_reg.pdest;
    assign iq.issue_payload_o = issue_reg.payload;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed dispatch/wakeup/stall/flush/reset scenarios.
module tb_alu_issue_queue;

    localparam int DEPTH = 8, PREG_W = 6, PAYLOAD_W = 64, WB_PORTS = 2;
`ifdef ALU_IQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int pdest;
        int exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic a_rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_queue_if #(.PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .WB_PORTS(WB_PORTS)) iq ();

    alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .WB_PORTS(WB_PORTS)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .iq    (iq)
    );

    function automatic logic [63:0] payload_of(input int pd);
        return {32'hC0DE_F00D, pd[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input int pd, input int s0, input bit r0, input int s1, input bit r1);
        iq.dispatch_valid_i   = 1'b1;
        iq.dispatch_pdest_i   = PREG_W'(pd);
        iq.dispatch_psrc0_i   = PREG_W'(s0);
        iq.dispatch_psrc1_i   = PREG_W'(s1);
        iq.dispatch_rdy0_i    = r0;
        iq.dispatch_rdy1_i    = r1;
        iq.dispatch_payload_i = payload_of(pd);
    endtask

    task automatic clr_disp();
        iq.dispatch_valid_i = 1'b0;
    endtask

    task automatic wake(input int t0, input bit v0, input int t1, input bit v1);
        iq.wb_valid_i   = {v1, v0};
        iq.wb_preg_i[0] = PREG_W'(t0);
        iq.wb_preg_i[1] = PREG_W'(t1);
    endtask

    // Monitor: every accepted issue is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!a_rst && iq.issue_valid_o && iq.issue_ready_i) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_issue: got pdest %0d, required no issue (cycle %0d)", iq.issue_pdest_o, cyc);
            end else begin
                e = sb.pop_front();
                check("issue_pdest", 64'(iq.issue_pdest_o), 64'(e.pdest));
                check("issue_payload", iq.issue_payload_o, payload_of(e.pdest));
                if (e.exp_cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.exp_cyc));
                $display("issue pdest=%0d cycle=%0d", iq.issue_pdest_o, cyc);
            end
        end
    end

    initial begin
        int d, w, b, r;
        int wk0[4];
        int wk1[4];
        int tail[7];
        wk0  = '{32, 34, 36, 39};
        wk1  = '{33, 35, 38, 0};
        tail = '{20, 21, 22, 23, 24, 26, 27};

        iq.flush_i = 1'b0;
        iq.issue_ready_i = 1'b1;
        clr_disp();
        set_disp(0, 0, 0, 0, 0);
        clr_disp();
        wake(0, 0, 0, 0);
        repeat (3) tick();
        check("rst_dispatch_ready", 64'(iq.dispatch_ready_o), 64'd1);
        check("rst_issue_valid", 64'(iq.issue_valid_o), 64'd0);
        check("rst_issue_pdest", 64'(iq.issue_pdest_o), 64'd0);
        check("rst_issue_payload", iq.issue_payload_o, 64'd0);
        a_rst = 1'b0;
        repeat (2) tick();

        // Three all-ready ops issue back to back in order.
        d = cyc;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1 + i, d + i + LAT});
            set_disp(1 + i, 5, 1, 6, 1);
            tick();
        end
        clr_disp();
        repeat (5) tick();

        // A waits on tag 9, younger B overtakes; wakeup at w issues A at w+2.
        d = cyc;
        set_disp(10, 9, 0, 1, 1);
        tick();
        sb.push_back('{11, d + 3});
        set_disp(11, 1, 1, 1, 1);
        tick();
        clr_disp();
        repeat (3) tick();
        w = cyc;
        sb.push_back('{10, w + 2});
        wake(9, 1, 0, 0);
        tick();
        wake(0, 0, 0, 0);
        repeat (4) tick();

        // Fill with unready ops, a refused extra dispatch, then wake entry 5.
        for (int i = 0; i < 8; i++) begin
            set_disp(20 + i, 32 + i, 0, 2, 1);
            tick();
        end
        clr_disp();
        check("full_ready_low", 64'(iq.dispatch_ready_o), 64'd0);
        set_disp(28, 1, 1, 1, 1);
        tick();
        clr_disp();
        w = cyc;
        sb.push_back('{25, w + 2});
        wake(37, 1, 0, 0);
        tick();
        wake(0, 0, 0, 0);
        check("full_ready_still_low", 64'(iq.dispatch_ready_o), 64'd0);
        tick();
        check("ready_after_issue", 64'(iq.dispatch_ready_o), 64'd1);
        tick();

        // Stall the issue register for 4 cycles while the rest wake up.
        iq.issue_ready_i = 1'b0;
        b = cyc;
        set_disp(29, 1, 1, 1, 1);
        tick();
        clr_disp();
        tick();
        for (int k = 0; k < 4; k++) begin
            wake(wk0[k], 1, wk1[k], k < 3);
            check("stall_valid", 64'(iq.issue_valid_o), 64'd1);
            check("stall_pdest", 64'(iq.issue_pdest_o), 64'd29);
            tick();
        end
        wake(0, 0, 0, 0);
        r = cyc;
        check("stall_release_pdest", 64'(iq.issue_pdest_o), 64'd29);
        sb.push_back('{29, -1});
        for (int i = 0; i < 7; i++) sb.push_back('{tail[i], r + 1 + i});
        iq.issue_ready_i = 1'b1;
        repeat (10) tick();

        // Same-cycle wakeup of a dispatching op's second source.
        d = cyc;
        sb.push_back('{40, d + LAT});
        set_disp(40, 3, 1, 4, 0);
        wake(0, 0, 4, 1);
        tick();
        clr_disp();
        wake(0, 0, 0, 0);
        repeat (4) tick();

        // Flush with a stalled issue register and five queued ops.
        iq.issue_ready_i = 1'b0;
        set_disp(50, 1, 1, 1, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_disp(51 + i, 60 + i, 0, 1, 1);
            tick();
        end
        clr_disp();
        repeat (2) tick();
        check("preflush_valid", 64'(iq.issue_valid_o), 64'd1);
        iq.flush_i = 1'b1;
        tick();
        iq.flush_i = 1'b0;
        check("flush_issue_valid", 64'(iq.issue_valid_o), 64'd0);
        check("flush_dispatch_ready", 64'(iq.dispatch_ready_o), 64'd1);
        iq.issue_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) wake(60, 1, 61, 1);
            else if (k == 1) wake(62, 1, 63, 1);
            else if (k == 2) wake(0, 0, 0, 0);
            else wake(64, 1, 0, 0);
            tick();
            check("postflush_idle", 64'(iq.issue_valid_o), 64'd0);
        end
        wake(0, 0, 0, 0);
        d = cyc;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{12 + i, d + i + LAT});
            set_disp(12 + i, 5, 1, 6, 1);
            tick();
        end
        clr_disp();
        repeat (5) tick();

        // Count restarted from zero: exactly eight unready ops fill the queue.
        for (int i = 0; i < 8; i++) begin
            set_disp(30 + i, 40 + i, 0, 1, 1);
            tick();
            if (i == 6) check("fill7_ready", 64'(iq.dispatch_ready_o), 64'd1);
        end
        clr_disp();
        check("fill8_ready", 64'(iq.dispatch_ready_o), 64'd0);

        // Asynchronous reset mid-cycle with a held op in the issue register.
        iq.issue_ready_i = 1'b0;
        wake(40, 1, 0, 0);
        tick();
        wake(0, 0, 0, 0);
        tick();
        check("prereset_pdest", 64'(iq.issue_pdest_o), 64'd30);
        #2;
        a_rst = 1'b1;
        #1;
        check("areset_valid", 64'(iq.issue_valid_o), 64'd0);
        check("areset_pdest", 64'(iq.issue_pdest_o), 64'd0);
        check("areset_payload", iq.issue_payload_o, 64'd0);
        check("areset_ready", 64'(iq.dispatch_ready_o), 64'd1);
        tick();
        a_rst = 1'b0;
        iq.issue_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) wake(41 + 2 * k, 1, 42 + 2 * k, k < 3);
            else wake(0, 0, 0, 0);
            tick();
        end
        check("postreset_idle", 64'(iq.issue_valid_o), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
